// File: rtl/slot_pkg.sv
// Shared definitions for the one-arm-bandit datapath: game state codes,
// refund FSM encodings and BCD digit geometry.
package slot_pkg;

    typedef enum logic [3:0] {
        WELCOME = 4'h0,
        GAME    = 4'h1,
        SCORE   = 4'h2,
        ERROR   = 4'h3,
        COIN    = 4'h4
    } game_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } refund_state_e;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_W       = 3 * BCD_DIGIT_W;

endpackage

// File: rtl/credit_bin2bcd.sv
// Registered binary to 3-digit BCD converter (double dabble); output lags
// the binary input by one clock.
module credit_bin2bcd
    import slot_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CREDIT_W-1:0] bin,
    output logic [BCD_W-1:0]    bcd
);

    function automatic logic [BCD_W-1:0] to_bcd(input logic [CREDIT_W-1:0] v);
        logic [BCD_W-1:0] acc;
        acc = '0;
        for (int i = CREDIT_W - 1; i >= 0; i--) begin
            for (int d = 0; d < 3; d++) begin
                if (acc[d*BCD_DIGIT_W +: BCD_DIGIT_W] >= BCD_DIGIT_W'(5))
                    acc[d*BCD_DIGIT_W +: BCD_DIGIT_W] =
                        acc[d*BCD_DIGIT_W +: BCD_DIGIT_W] + BCD_DIGIT_W'(3);
            end
            acc = {acc[BCD_W-2:0], v[i]};
        end
        return acc;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bcd <= '0;
        else
            bcd <= to_bcd(bin);
    end

endmodule

// File: rtl/credit_bank.sv
// Credit register for the slot machine: coins, bet debit handshake, saturating
// payout and BCD display. Optional hopper refund drain under macro COIN_REFUND_EN.
module credit_bank
    import slot_pkg::*;
#(
    parameter int                         CREDIT_W   = 8,
    parameter int                         CREDIT_MAX = 99,
    parameter int                         NUM_CH     = 2,
    parameter logic [NUM_CH*CREDIT_W-1:0] COIN_VALS  = {8'd5, 8'd1},
    parameter int                         BET_W      = 4,
    parameter int                         WIN_W      = CREDIT_W,
    parameter int                         REFUND_GAP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          cur_state,
    input  logic [NUM_CH-1:0]   coin_p,
    input  logic                bet_req,
    input  logic [BET_W-1:0]    bet_amt,
    input  logic                win_p,
    input  logic [WIN_W-1:0]    win_amt,
    input  logic                refund_req,
    output logic [CREDIT_W-1:0] credit,
    output logic [BCD_W-1:0]    credit_bcd,
    output logic                credit_zero,
    output logic                bet_ok,
    output logic                bet_fail,
    output logic                coin_sat,
    output logic                refund_p,
    output logic                refund_busy
);

    localparam int               SUM_W   = CREDIT_W + WIN_W + 2;
    localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'(CREDIT_MAX);

    function automatic logic [CREDIT_W-1:0] sat_credit(input logic [SUM_W-1:0] v);
        return (v > MAX_EXT) ? CREDIT_W'(CREDIT_MAX) : v[CREDIT_W-1:0];
    endfunction

    logic             drain;
    logic             refund_fire;
    logic             bet_take;
    logic [SUM_W-1:0] credit_ext;
    logic [SUM_W-1:0] debit;
    logic [SUM_W-1:0] add;
    logic [SUM_W-1:0] sum;

    // Debit is judged against the registered credit only, so a bet can never
    // be funded by a coin or win landing in the same cycle.
    always_comb begin
        credit_ext = SUM_W'(credit);
        bet_take   = bet_req && (bet_amt != '0) && (SUM_W'(bet_amt) <= credit_ext) && !drain;
        debit      = bet_take ? SUM_W'(bet_amt) : '0;
        add        = '0;
        if (cur_state == COIN) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (coin_p[i])
                    add = add + SUM_W'(COIN_VALS[i*CREDIT_W +: CREDIT_W]);
            end
        end
        if (win_p)
            add = add + SUM_W'(win_amt);
        sum = credit_ext - debit + add;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit   <= '0;
            bet_ok   <= 1'b0;
            bet_fail <= 1'b0;
            coin_sat <= 1'b0;
        end else begin
            bet_ok   <= bet_take;
            bet_fail <= bet_req && !bet_take;
            if (drain) begin
                credit   <= credit - CREDIT_W'(refund_fire);
                coin_sat <= 1'b0;
            end else begin
                credit   <= sat_credit(sum);
                coin_sat <= (sum > MAX_EXT);
            end
        end
    end

    assign credit_zero = (credit == '0);

    credit_bin2bcd #(.CREDIT_W(CREDIT_W)) u_bin2bcd (
        .clk (clk),
        .rst (rst),
        .bin (credit),
        .bcd (credit_bcd)
    );

`ifdef COIN_REFUND_EN
    localparam int GAP_W = $clog2(REFUND_GAP) + 1;

    refund_state_e    rf_state;
    refund_state_e    rf_next;
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rf_state <= IDLE;
        else
            rf_state <= rf_next;
    end

    // Pulse on the first DRAIN cycle, then every REFUND_GAP cycles.
    always_comb begin
        rf_next     = rf_state;
        refund_fire = 1'b0;
        case (rf_state)
            IDLE: begin
                if (refund_req && (cur_state == WELCOME || cur_state == COIN) && credit != '0)
                    rf_next = DRAIN;
            end
            DRAIN: begin
                if (gap_cnt == '0) begin
                    refund_fire = 1'b1;
                    if (credit == CREDIT_W'(1))
                        rf_next = DONE;
                end
            end
            DONE:    rf_next = IDLE;
            default: rf_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt  <= '0;
            refund_p <= 1'b0;
        end else begin
            refund_p <= refund_fire;
            if (rf_state != DRAIN)
                gap_cnt <= '0;
            else if (refund_fire)
                gap_cnt <= GAP_W'(REFUND_GAP - 1);
            else
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    assign drain       = (rf_state == DRAIN);
    assign refund_busy = (rf_state != IDLE);
`else
    localparam int unused_refund_gap = REFUND_GAP;
    logic          unused_refund_req;

    assign unused_refund_req = refund_req;
    assign drain             = 1'b0;
    assign refund_fire       = 1'b0;
    assign refund_p          = 1'b0;
    assign refund_busy       = 1'b0;
`endif

endmodule
